// File: rtl/fp_mul_iter.sv
// rtl/fp_mul_iter.sv - iterative shift-add IEEE-754 style floating-point multiplier
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high; aborts any operation in flight
//   i_valid  operands i_a/i_b valid; accepted when o_ready is also high
//   o_ready  high only while idle
//   i_a/i_b  operands {sign, exponent[EXP_W], fraction[MAN_W]}
//   o_valid  one-cycle pulse when o_res/o_flags are updated
//   o_res    product, held until the next result
//   o_flags  {invalid, overflow, underflow, inexact}
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  output logic                   o_valid,
  output logic [EXP_W+MAN_W:0]   o_res,
  output logic [3:0]             o_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * N;              // full product width
  localparam int EW = EXP_W + 2;          // signed exponent arithmetic width
  localparam int CW = $clog2(N + 1);

  localparam logic [EXP_W-1:0]      EXP_MAX = '1;
  localparam logic signed [EW-1:0]  BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]         EXP_INF = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                 state;
  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic [PW-1:0]          mcand;
  logic [N-1:0]           mplier;
  logic [PW-1:0]          acc;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   exp_sum_q;
  logic [N-1:0]           nm_mant;
  logic [EW-1:0]          nm_exp;
  logic                   nm_g, nm_r, nm_s, nm_tiny;

  // ---------------- unpack ----------------
  logic [EXP_W-1:0]       ea_f, eb_f, ea_eff, eb_eff;
  logic [MAN_W-1:0]       fa, fb;
  logic [N-1:0]           ma, mb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic signed [EW-1:0]   exp_sum;
  logic                   spec_hit;
  logic [W-1:0]           spec_res;
  logic [3:0]             spec_flags;

  assign ea_f   = a_q[W-2 -: EXP_W];
  assign eb_f   = b_q[W-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign sgn    = a_q[W-1] ^ b_q[W-1];
  assign a_zero = (ea_f == '0) && (fa == '0);
  assign b_zero = (eb_f == '0) && (fb == '0);
  assign a_inf  = (ea_f == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb_f == EXP_MAX) && (fb == '0);
  assign a_nan  = (ea_f == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb_f == EXP_MAX) && (fb != '0);
  // Subnormals carry a zero hidden bit but the exponent of the smallest normal.
  assign ma     = {ea_f != '0, fa};
  assign mb     = {eb_f != '0, fb};
  assign ea_eff = (ea_f == '0) ? EXP_W'(1) : ea_f;
  assign eb_eff = (eb_f == '0) ? EXP_W'(1) : eb_f;
  assign exp_sum = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - BIAS;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res = '1;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_res   = '1;
      spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_res = {sgn, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------- normalise ----------------
  // The product's binary point sits below bit 2*MAN_W. One combined shift
  // moves the leading one onto bit 2*MAN_W and, when the exponent would drop
  // below 1, continues right into the subnormal range, folding lost bits
  // into sticky.
  int                     norm_pos, norm_e, norm_sh;
  logic [PW-1:0]          norm_y;
  logic                   norm_stk;

  always_comb begin
    norm_pos = 0;
    norm_e   = 0;
    norm_sh  = 0;
    norm_y   = '0;
    norm_stk = 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (acc[i]) norm_pos = i;
    end
    norm_e  = int'(exp_sum_q) + norm_pos - 2 * MAN_W;
    norm_sh = norm_pos - 2 * MAN_W;
    if (norm_e < 1) begin
      norm_sh = norm_sh + 1 - norm_e;
      norm_e  = 1;
    end
    if (norm_sh >= 0) begin
      if (norm_sh > PW) norm_sh = PW;
      norm_y   = acc >> norm_sh;
      norm_stk = |(acc & ~({PW{1'b1}} << norm_sh));
    end else begin
      norm_y   = acc << (-norm_sh);
      norm_stk = 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{norm_y[PW-1], norm_e[31:EW]};

  // ---------------- round ----------------
  logic                   rnd_up, rnd_inexact;
  logic [N:0]             rnd_sum;
  logic [N-1:0]           rnd_man;
  logic [EW-1:0]          rnd_exp;
  logic [W-1:0]           rnd_res;
  logic [3:0]             rnd_flags;

  always_comb begin
    rnd_up      = nm_g & (nm_r | nm_s | nm_mant[0]);
    rnd_inexact = nm_g | nm_r | nm_s;
    rnd_sum     = {1'b0, nm_mant} + {{N{1'b0}}, rnd_up};
    rnd_man     = rnd_sum[N-1:0];
    rnd_exp     = nm_exp;
    // Carry out means the significand wrapped to 10..0: renormalise.
    if (rnd_sum[N]) begin
      rnd_man = rnd_sum[N:1];
      rnd_exp = nm_exp + 1'b1;
    end
    rnd_res   = '0;
    rnd_flags = '0;
    if (rnd_man[MAN_W] && (rnd_exp >= EXP_INF)) begin
      rnd_res   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else begin
      // A zero hidden bit after rounding encodes as a subnormal (or zero).
      rnd_res   = {sign_q, (rnd_man[MAN_W] ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}}),
                   rnd_man[MAN_W-1:0]};
      rnd_flags = {2'b00, nm_tiny & rnd_inexact, rnd_inexact};
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_res     <= '0;
      o_flags   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      exp_sum_q <= '0;
      nm_mant   <= '0;
      nm_exp    <= '0;
      nm_g      <= 1'b0;
      nm_r      <= 1'b0;
      nm_s      <= 1'b0;
      nm_tiny   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            a_q     <= i_a;
            b_q     <= i_b;
            o_ready <= 1'b0;
            state   <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= sgn;
          if (spec_hit) begin
            o_res   <= spec_res;
            o_flags <= spec_flags;
            o_valid <= 1'b1;
            state   <= S_DONE;
          end else begin
            acc       <= '0;
            mcand     <= {{N{1'b0}}, ma};
            mplier    <= mb;
            cnt       <= '0;
            exp_sum_q <= exp_sum;
            state     <= S_MULT;
          end
        end
        S_MULT: begin
          // One multiplier bit per cycle, LSB first.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= S_NORM;
        end
        S_NORM: begin
          nm_mant <= norm_y[2*MAN_W -: N];
          nm_exp  <= norm_e[EW-1:0];
          nm_g    <= norm_y[MAN_W-1];
          nm_r    <= norm_y[MAN_W-2];
          nm_s    <= (|norm_y[MAN_W-3:0]) | norm_stk;
          nm_tiny <= ~norm_y[2*MAN_W];
          state   <= S_ROUND;
        end
        S_ROUND: begin
          o_res   <= rnd_res;
          o_flags <= rnd_flags;
          o_valid <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// tb/tb_fp_mul_iter.sv - self-checking bench for fp_mul_iter (binary32 and binary16 instances)
module tb_fp_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_iv, s_or, s_ov;
  logic [31:0] s_a, s_b, s_res;
  logic [3:0]  s_fl;
  logic        h_iv, h_or, h_ov;
  logic [15:0] h_a, h_b, h_res;
  logic [3:0]  h_fl;

  fp_mul_iter dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(s_iv), .o_ready(s_or),
    .i_a(s_a), .i_b(s_b), .o_valid(s_ov), .o_res(s_res), .o_flags(s_fl)
  );

  fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .i_clk(clk), .i_rst(rst), .i_valid(h_iv), .o_ready(h_or),
    .i_a(h_a), .i_b(h_b), .o_valid(h_ov), .o_res(h_res), .o_flags(h_fl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        special;
    logic [3:0]  flags;
    logic [63:0] res;
  } ref_t;

  // Exact product value = ma*mb * 2^(ea+eb-2*bias-2*mw); rounded to the
  // quantum 2^(E-mw) of the result binade, E clamped at the minimum normal.
  function automatic ref_t ref_mul(input logic [63:0] a, input logic [63:0] b,
                                   input int ew, input int mw);
    ref_t r;
    logic [63:0] fmask, fa, fb, xa, xb, ma, mb;
    logic sg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, tiny, inex, up;
    int bias, emax, ea, eb, p, lg, e, k, biased;
    logic [127:0] prod, q, rem, half;
    r = '0;
    fmask = (64'd1 << mw) - 64'd1;
    emax  = (1 << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    fa = a & fmask;
    fb = b & fmask;
    xa = (a >> mw) & 64'(emax);
    xb = (b >> mw) & 64'(emax);
    sg = a[ew+mw] ^ b[ew+mw];
    a_nan  = (xa == 64'(emax)) && (fa != 0);
    b_nan  = (xb == 64'(emax)) && (fb != 0);
    a_inf  = (xa == 64'(emax)) && (fa == 0);
    b_inf  = (xb == 64'(emax)) && (fb == 0);
    a_zero = (xa == 0) && (fa == 0);
    b_zero = (xb == 0) && (fb == 0);
    r.special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    if (a_nan || b_nan) begin
      r.res = (64'd1 << (1 + ew + mw)) - 64'd1;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      r.res   = (64'd1 << (1 + ew + mw)) - 64'd1;
      r.flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      r.res = (64'(sg) << (ew + mw)) | (64'(emax) << mw);
    end else if (a_zero || b_zero) begin
      r.res = 64'(sg) << (ew + mw);
    end else begin
      ma = (xa == 0) ? fa : (fa | (64'd1 << mw));
      mb = (xb == 0) ? fb : (fb | (64'd1 << mw));
      ea = (xa == 0) ? 1 : int'(xa);
      eb = (xb == 0) ? 1 : int'(xb);
      prod = 128'(ma) * 128'(mb);
      p = 0;
      for (int i = 0; i < 128; i++) if (prod[i]) p = i;
      lg   = p + ea + eb - 2 * bias - 2 * mw;
      tiny = (lg < 1 - bias);
      e    = tiny ? (1 - bias) : lg;
      k    = (e - mw) - (ea + eb - 2 * bias - 2 * mw);
      up   = 1'b0;
      inex = 1'b0;
      if (k <= 0) begin
        q = prod << (-k);
      end else if (k > 120) begin
        q    = '0;
        inex = 1'b1;
      end else begin
        q    = prod >> k;
        rem  = prod & ((128'd1 << k) - 128'd1);
        half = 128'd1 << (k - 1);
        inex = (rem != 0);
        up   = (rem > half) || ((rem == half) && q[0]);
      end
      if (up) q = q + 128'd1;
      if (q >= (128'd1 << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      biased = (q >= (128'd1 << mw)) ? (e + bias) : 0;
      if (biased >= emax) begin
        r.res   = (64'(sg) << (ew + mw)) | (64'(emax) << mw);
        r.flags = 4'b0101;
      end else begin
        r.res   = (64'(sg) << (ew + mw)) | (64'(biased) << mw) | (q[63:0] & fmask);
        r.flags = {2'b00, tiny & inex, inex};
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_op(input int ew, input int mw);
    int bias, emax, cls;
    logic [63:0] f, x, s;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    cls  = int'($urandom_range(0, 19));
    f    = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    s    = 64'($urandom_range(0, 1));
    x    = 64'($urandom_range(bias - bias / 2, bias + bias / 2));
    case (cls)
      0: begin x = 0; f = 0; end
      1: begin x = 64'(emax); f = 0; end
      2: begin x = 64'(emax); f = f | 64'd1; end
      3, 4: begin x = 0; if (f == 0) f = 64'd1; end
      5, 6: x = 64'($urandom_range(1, emax - 1));
      7, 8: f = f & ~((64'd1 << (mw / 2)) - 64'd1);
      default: ;
    endcase
    return (s << (ew + mw)) | (x << mw) | f;
  endfunction

  // Entered and left #1 after a rising edge.
  task automatic do_s(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output logic [3:0] fl,
                      output int lat, output logic width_ok);
    int guard;
    guard = 0;
    while (!s_or && guard < 100) begin @(posedge clk); #1; guard++; end
    s_a = a; s_b = b; s_iv = 1'b1;
    @(posedge clk); #1;
    s_iv = 1'b0;
    lat = 1;
    while (!s_ov && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!s_ov) lat = -1;
    res = s_res;
    fl  = s_fl;
    @(posedge clk); #1;
    width_ok = !s_ov;
  endtask

  task automatic do_h(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] res, output logic [3:0] fl,
                      output int lat);
    int guard;
    guard = 0;
    while (!h_or && guard < 100) begin @(posedge clk); #1; guard++; end
    h_a = a; h_b = b; h_iv = 1'b1;
    @(posedge clk); #1;
    h_iv = 1'b0;
    lat = 1;
    while (!h_ov && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!h_ov) lat = -1;
    res = h_res;
    fl  = h_fl;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (s_or !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_or); end
    n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", s_ov); end
    n_checks++; if (s_res !== 32'h0) begin n_fail++; $display("FAIL reset_res: got %h expected 0", s_res); end
    n_checks++; if (s_fl !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", s_fl); end
    n_checks++; if (h_or !== 1'b1) begin n_fail++; $display("FAIL reset_ready_h: got %b expected 1", h_or); end
  endtask

  task automatic test_basic;
    logic [31:0] r; logic [3:0] f; int lat; logic w;
    do_s(32'hC000_0000, 32'h3E00_0000, r, f, lat, w);
    n_checks++; if (r !== 32'hBE80_0000) begin n_fail++; $display("FAIL basic_res: got %h expected be800000", r); end
    n_checks++; if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b expected 0000", f); end
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL basic_latency: got %0d expected 28", lat); end
    n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL basic_pulse_width: o_valid still high next cycle"); end
  endtask

  task automatic test_back_to_back;
    int pulses, accepts, guard;
    int t[2];
    logic [31:0] r[2];
    logic [3:0]  f[2];
    logic prev_ready;
    guard = 0;
    while (!s_or && guard < 100) begin @(posedge clk); #1; guard++; end
    s_a = 32'h4060_0000; s_b = 32'h425D_0000; s_iv = 1'b1;
    prev_ready = s_or;
    accepts = 0; pulses = 0;
    t[0] = -1; t[1] = -1; r[0] = '0; r[1] = '0; f[0] = '0; f[1] = '0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      if (prev_ready && s_iv) accepts++;
      #1;
      if (accepts == 1) begin s_a = 32'hC000_0000; s_b = 32'h3E00_0000; end
      if (accepts >= 2) s_iv = 1'b0;
      if (s_ov) begin
        if (pulses < 2) begin t[pulses] = n + 1; r[pulses] = s_res; f[pulses] = s_fl; end
        pulses++;
      end
      prev_ready = s_or;
    end
    s_iv = 1'b0;
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
    n_checks++; if (r[0] !== 32'h4341_6000) begin n_fail++; $display("FAIL b2b_res0: got %h expected 43416000", r[0]); end
    n_checks++; if (f[0] !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags0: got %b expected 0000", f[0]); end
    n_checks++; if (t[0] !== 28) begin n_fail++; $display("FAIL b2b_time0: got %0d expected 28", t[0]); end
    n_checks++; if (r[1] !== 32'hBE80_0000) begin n_fail++; $display("FAIL b2b_res1: got %h expected be800000", r[1]); end
    n_checks++; if (t[1] !== 57) begin n_fail++; $display("FAIL b2b_time1: got %0d expected 57", t[1]); end
  endtask

  task automatic test_specials;
    logic [31:0] va[4], vb[4], er[4];
    logic [3:0]  ef[4];
    logic [31:0] r; logic [3:0] f; int lat; logic w;
    va[0] = 32'h7F80_0000; vb[0] = 32'h0000_0000; er[0] = 32'hFFFF_FFFF; ef[0] = 4'b1000;
    va[1] = 32'h7F80_0000; vb[1] = 32'hFF80_0000; er[1] = 32'hFF80_0000; ef[1] = 4'b0000;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; er[2] = 32'h0000_0000; ef[2] = 4'b0000;
    va[3] = 32'h7FC0_0000; vb[3] = 32'h3F80_0000; er[3] = 32'hFFFF_FFFF; ef[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      do_s(va[i], vb[i], r, f, lat, w);
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL special%0d_res: got %h expected %h", i, r, er[i]); end
      n_checks++; if (f !== ef[i]) begin n_fail++; $display("FAIL special%0d_flags: got %b expected %b", i, f, ef[i]); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL special%0d_latency: got %0d expected 2", i, lat); end
    end
  endtask

  task automatic test_over_under;
    logic [31:0] r; logic [3:0] f; int lat; logic w;
    do_s(32'h4091_EB85, 32'h7F40_0000, r, f, lat, w);
    n_checks++; if (r !== 32'h7F80_0000) begin n_fail++; $display("FAIL overflow_res: got %h expected 7f800000", r); end
    n_checks++; if (f !== 4'b0101) begin n_fail++; $display("FAIL overflow_flags: got %b expected 0101", f); end
    do_s(32'h0000_0002, 32'h807F_FFFF, r, f, lat, w);
    n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL underflow_res: got %h expected 80000000", r); end
    n_checks++; if (f !== 4'b0011) begin n_fail++; $display("FAIL underflow_flags: got %b expected 0011", f); end
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL underflow_latency: got %0d expected 28", lat); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    s_a = 32'h4060_0000; s_b = 32'h425D_0000; s_iv = 1'b1;
    @(posedge clk); #1;
    s_iv = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (s_or !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", s_or); end
    n_checks++; if (s_res !== 32'h0) begin n_fail++; $display("FAIL midreset_res: got %h expected 0", s_res); end
    n_checks++; if (s_fl !== 4'h0) begin n_fail++; $display("FAIL midreset_flags: got %b expected 0000", s_fl); end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (s_ov) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_valid_held;
    int pulses, first, busy_ready, cyc;
    pulses = 0; first = -1; busy_ready = 0;
    s_a = 32'h3FC0_0000; s_b = 32'h4000_0000; s_iv = 1'b1;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      cyc = n + 1;
      if (s_ov) begin
        if (first < 0) first = cyc;
        pulses++;
        s_iv = 1'b0;
      end
      if (cyc <= 28 && s_or) busy_ready++;
    end
    s_iv = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL held_pulse_count: got %0d expected 1", pulses); end
    n_checks++; if (first !== 28) begin n_fail++; $display("FAIL held_latency: got %0d expected 28", first); end
    n_checks++; if (busy_ready !== 0) begin n_fail++; $display("FAIL held_ready_busy: ready high %0d busy cycles expected 0", busy_ready); end
    n_checks++; if (s_res !== 32'h4040_0000) begin n_fail++; $display("FAIL held_res: got %h expected 40400000", s_res); end
  endtask

  task automatic test_param16;
    logic [15:0] r; logic [3:0] f; int lat;
    do_h(16'h4000, 16'h3E00, r, f, lat);
    n_checks++; if (r !== 16'h4200) begin n_fail++; $display("FAIL half_res: got %h expected 4200", r); end
    n_checks++; if (f !== 4'b0000) begin n_fail++; $display("FAIL half_flags: got %b expected 0000", f); end
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL half_latency: got %0d expected 15", lat); end
  endtask

  task automatic test_random;
    logic [63:0] a, b;
    ref_t e;
    logic [31:0] r; logic [3:0] f; int lat; logic w;
    logic [15:0] rh; logic [3:0] fh; int lath;
    for (int i = 0; i < 120; i++) begin
      a = rand_op(8, 23);
      b = rand_op(8, 23);
      e = ref_mul(a, b, 8, 23);
      do_s(a[31:0], b[31:0], r, f, lat, w);
      n_checks++; if (r !== e.res[31:0]) begin n_fail++; $display("FAIL rand32_res %h*%h: got %h expected %h", a[31:0], b[31:0], r, e.res[31:0]); end
      n_checks++; if (f !== e.flags) begin n_fail++; $display("FAIL rand32_flags %h*%h: got %b expected %b", a[31:0], b[31:0], f, e.flags); end
      n_checks++; if (lat !== (e.special ? 2 : 28)) begin n_fail++; $display("FAIL rand32_latency %h*%h: got %0d", a[31:0], b[31:0], lat); end
    end
    for (int i = 0; i < 60; i++) begin
      a = rand_op(5, 10);
      b = rand_op(5, 10);
      e = ref_mul(a, b, 5, 10);
      do_h(a[15:0], b[15:0], rh, fh, lath);
      n_checks++; if (rh !== e.res[15:0]) begin n_fail++; $display("FAIL rand16_res %h*%h: got %h expected %h", a[15:0], b[15:0], rh, e.res[15:0]); end
      n_checks++; if (fh !== e.flags) begin n_fail++; $display("FAIL rand16_flags %h*%h: got %b expected %b", a[15:0], b[15:0], fh, e.flags); end
      n_checks++; if (lath !== (e.special ? 2 : 15)) begin n_fail++; $display("FAIL rand16_latency %h*%h: got %0d", a[15:0], b[15:0], lath); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_iv = 1'b0; s_a = '0; s_b = '0;
    h_iv = 1'b0; h_a = '0; h_b = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_specials;
    test_over_under;
    test_reset_mid;
    test_valid_held;
    test_param16;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_iter.md
Name: fp_mul_iter

Overview:
- Parametrised, multi-cycle IEEE-754 style floating-point multiplier. Successor to the single-precision `floating` multiplier.
- Generalised over exponent and mantissa width: half, single, double or custom formats.
- Adds a valid/ready handshake, round-to-nearest-even, gradual underflow and exception flags.
- Mantissa product is formed by an iterative shift-add datapath driven by an FSM. Sits between operand registers and the result bus of the arithmetic unit.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored fraction width (no hidden bit)
- W = 1+EXP_W+MAN_W is derived (localparam), not overridable.

Ports:
- i_clk    in   1    clock, rising edge
- i_rst    in   1    synchronous reset, active-high
- i_valid  in   1    operands i_a/i_b valid
- o_ready  out  1    block idle, accepts operands this cycle
- i_a      in   W    operand A
- i_b      in   W    operand B
- o_valid  out  1    one-cycle pulse, o_res/o_flags updated
- o_res    out  W    product, registered, held until next result
- o_flags  out  4    {invalid, overflow, underflow, inexact}, registered with o_res

Behaviour:
- Reset: all outputs 0 except o_ready=1; state IDLE. Any in-flight operation is aborted with no o_valid.
- Accept happens on an edge where state==IDLE and i_valid&o_ready. Operands are latched. o_ready=1 only in IDLE. i_valid while busy is ignored and never queued.
- FSM: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE -> IDLE.
  - UNPACK has a special-case bypass straight to DONE.
- UNPACK:
  - sign = a.s^b.s.
  - Subnormal input: hidden bit 0, effective exponent 1.
  - Normal input: hidden bit 1.
  - Special cases resolved here.
- MULT: exactly MAN_W+1 cycles. One multiplier bit per cycle, LSB first, into a 2*(MAN_W+1)-bit accumulator.
- NORM (1 cycle):
  - Leading-one normalise: shift left for subnormal products, right by 1 if product ≥ 2.
  - Exponent sum uses EXP_W+2-bit signed arithmetic.
  - If exponent < 1: right-shift into subnormal range, OR-ing shifted-out bits into sticky.
- ROUND (1 cycle):
  - Round to nearest, ties to even, using guard/round/sticky.
  - Mantissa carry-out increments the exponent; a subnormal rounding up to min-normal becomes normal.
- DONE: o_valid=1 for exactly one cycle; o_res/o_flags loaded on entry.
- Latency, normal path: o_valid high in cycle MAN_W+5 after the accept edge (28 for defaults).
- Latency, special path: o_valid high in cycle 2 after the accept edge.
- Max throughput is one op per latency+1 cycles.
- Special cases (UNPACK bypass):
  - Either input NaN -> canonical NaN, all ones, sign 1. Invalid flag only for Inf*0.
  - Inf*0 -> canonical NaN, invalid=1.
  - Inf*nonzero -> sign-correct Inf.
  - 0*finite -> sign-correct zero (sign = XOR of input signs); no flags.
- Overflow (rounded exponent ≥ 2^EXP_W-1) -> signed Inf, overflow=1, inexact=1.
- underflow=1 when the result is tiny (subnormal or zero before rounding) and inexact.
- Result flushed to zero by rounding keeps its sign.
- inexact=1 whenever guard|round|sticky != 0.
- i_rst during any state: state IDLE next edge, no o_valid; o_res cleared.

Test Plan:
- Basic single: 0xC0000000 (-2.0) * 0x3E000000 (0.125) -> o_res=0xBE800000, flags=0, o_valid exactly 28 cycles after accept, one cycle wide.
- Rounding/normalise: 0x40600000 (3.5) * 0x425D0000 (55.25) -> 0x43416000 (193.375), flags=0. Back-to-back second op accepted only after o_ready returns high.
- Specials: 0x7F800000 * 0x00000000 -> 0xFFFFFFFF with invalid=1 in 2 cycles. 0x7F800000 * 0xFF800000 -> 0xFF800000. 0x80000000 * 0x80000000 -> 0x00000000.
- Overflow/underflow: 0x4091EB85 (4.56) * 0x7F400000 -> 0x7F800000, flags=0101. 0x00000002 * 0x807FFFFF -> 0x80000000, underflow=1, inexact=1.
- Control: i_rst pulsed mid-MULT -> no o_valid, o_ready=1 next cycle, o_res=0. i_valid held high during a busy op -> only one result produced per accept.
- Parametrisation, EXP_W=5, MAN_W=10: 0x4000 (2.0) * 0x3E00 (1.5) -> 0x4200 (3.0), o_valid 15 cycles after accept.
